id_stage: RTL and testbench
===========================

# id_stage

Instruction-decode stage of the 5-stage MIPS pipeline; sits directly downstream of the instruction-fetch stage and consumes its registered `Ins` and `nextPC`. Holds the 32×32 register file, decodes opcode/funct into control signals, and sign-extends immediates. Detects load-use hazards and presents one registered ID/EX bundle per cycle to the execute stage.

## Interface
- `IMM_W`, 16: immediate field width, sign-extended to 32.
- `CLK` in 1: clock; all state updates on rising edge.
- `RST` in 1: synchronous, active-high reset.
- `Ins` in 32: instruction from fetch stage.
- `nextPC` in 32: PC+4 from fetch stage.
- `W_RegWrite` in 1: writeback enable.
- `W_RegAddr` in 5: writeback destination.
- `W_Data` in 32: writeback data.
- `Flush` in 1: branch/jump taken in EX; squash the instruction decoded this cycle.
- `Stall` out 1: combinational load-use hazard; fetch must hold `newPC`/`Ins`.
- `E_PC` out 32: registered `nextPC`.
- `E_RsData`, `E_RtData` out 32: register-file read data.
- `E_Imm` out 32: sign-extended `Ins[15:0]`.
- `E_Rs`, `E_Rt`, `E_Rd` out 5; `E_Shamt` out 5; `E_Funct` out 6.
- `E_JAddr` out 32: `{nextPC[31:28], Ins[25:0], 2'b00}`.
- `E_RegWrite`, `E_MemRead`, `E_MemWrite`, `E_ALUSrc`, `E_RegDst`, `E_MemtoReg`, `E_Branch`, `E_Jump` out 1 each.
- `E_ALUOp` out 2: 00 add, 01 sub, 10 decode funct.

## Operation
- Decode table (op): 0x00 R-type (RegDst, RegWrite, ALUOp=10); 0x08 addi (ALUSrc, RegWrite, ALUOp=00); 0x23 lw (ALUSrc, MemRead, MemtoReg, RegWrite, ALUOp=00); 0x2b sw (ALUSrc, MemWrite, ALUOp=00); 0x04 beq (Branch, ALUOp=01); 0x02 j (Jump). Any other op: all controls 0 (NOP).
- Register file: 32 words; reg 0 reads 0 always, writes to 0 ignored. Write on posedge when `W_RegWrite`.
- Hazard: `Stall` = `E_MemRead` & `E_Rt`≠0 & (`E_Rt`==`Ins[25:21]` | (`E_Rt`==`Ins[20:16]` & op∈{R-type, sw, beq})) & ~`Flush`.
- Bubble: if `Stall` or `Flush`, next cycle all eight 1-bit controls and `E_ALUOp` load 0; data/field outputs load normally (don't care).
- Otherwise all `E_*` load decoded values of current `Ins`.
- `Flush` and `Stall` together: Flush wins, `Stall`=0, bubble inserted.

## Timing
- Latency 1 cycle: `Ins` at edge N → `E_*` valid after edge N.
- `Stall` combinational from `Ins` and registered `E_*`; asserted for exactly one cycle per load-use pair.
- Reset (`RST`=1 at edge): all `E_*` = 0, all 32 registers = 0; `Stall` = 0 after the reset edge. Reset overrides writeback and flush in the same cycle.
- Same-cycle write and read of the same register: see Configuration.

## Configuration
- `ID_BYPASS_EN` defined: read port returns `W_Data` when `W_RegWrite` & `W_RegAddr`≠0 & `W_RegAddr` equals the read address (write-through in the same cycle).
- Undefined: read returns the pre-write array value; downstream forwarding must cover it.

## Test plan
- Reset: hold `RST` 2 cycles, then `Ins`=0 → all `E_*`=0, `Stall`=0; read of every register = 0.
- Writeback then read: write r9=0x0000_00AB, next cycle `Ins`=0x012A4020 (add r8,r9,r10) → `E_RsData`=0xAB, `E_RegDst`=1, `E_ALUOp`=10, `E_Rd`=8.
- Immediate: `Ins`=0x2231FF00 (addi r17,r17,-256) → `E_Imm`=0xFFFFFF00, `E_ALUSrc`=1, `E_RegWrite`=1.
- Load-use: lw r8,0(r9) then add r10,r8,r11 → `Stall`=1 one cycle, next `E_*` controls all 0, then add decodes normally.
- Flush+stall: same load-use pair with `Flush`=1 → `Stall`=0, bubble issued.
- Bypass: write r5=0x1234 same cycle as `Ins` reading r5 → `E_RsData`=0x1234 with `ID_BYPASS_EN`, old value (0) without; write to r0 never changes reads.

Source files
------------

// File: rtl/id_stage.sv
// Decode stage: 32x32 register file, opcode decode, immediate extension,
// load-use stall detection and the registered ID/EX bundle. Optional ID_BYPASS_EN.
module id_stage #(
  parameter int IMM_W = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] Ins,
  input  logic [31:0] nextPC,
  input  logic        W_RegWrite,
  input  logic [4:0]  W_RegAddr,
  input  logic [31:0] W_Data,
  input  logic        Flush,
  output logic        Stall,
  output logic [31:0] E_PC,
  output logic [31:0] E_RsData,
  output logic [31:0] E_RtData,
  output logic [31:0] E_Imm,
  output logic [4:0]  E_Rs,
  output logic [4:0]  E_Rt,
  output logic [4:0]  E_Rd,
  output logic [4:0]  E_Shamt,
  output logic [5:0]  E_Funct,
  output logic [31:0] E_JAddr,
  output logic        E_RegWrite,
  output logic        E_MemRead,
  output logic        E_MemWrite,
  output logic        E_ALUSrc,
  output logic        E_RegDst,
  output logic        E_MemtoReg,
  output logic        E_Branch,
  output logic        E_Jump,
  output logic [1:0]  E_ALUOp
);

  typedef struct packed {
    logic       reg_write, mem_read, mem_write, alu_src;
    logic       reg_dst, mem_to_reg, branch, jump;
    logic [1:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc, rs_data, rt_data, imm, jaddr;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    ctrl_t       ctrl;
  } ex_t;

  localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h08, OP_LW = 6'h23,
                         OP_SW = 6'h2b, OP_BEQ = 6'h04, OP_J = 6'h02;

  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];
  ex_t         ex_q, ex_d;
  ctrl_t       ctrl;
  logic [5:0]  op;
  logic [4:0]  rs, rt;
  logic [31:0] rs_rd, rt_rd;
  logic        uses_rt, hazard;

  assign op = Ins[31:26];
  assign rs = Ins[25:21];
  assign rt = Ins[20:16];

  always_comb begin
    rf_d = rf_q;
    if (W_RegWrite && W_RegAddr != 5'd0) rf_d[W_RegAddr] = W_Data;
  end

  // Read ports; r0 is hardwired to zero regardless of array contents
  always_comb begin
    rs_rd = (rs == 5'd0) ? 32'd0 : rf_q[rs];
    rt_rd = (rt == 5'd0) ? 32'd0 : rf_q[rt];
`ifdef ID_BYPASS_EN
    if (W_RegWrite && W_RegAddr != 5'd0 && W_RegAddr == rs) rs_rd = W_Data;
    if (W_RegWrite && W_RegAddr != 5'd0 && W_RegAddr == rt) rt_rd = W_Data;
`endif
  end

  always_comb begin
    ctrl = '0;
    case (op)
      OP_R:    begin ctrl.reg_dst = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu_op = 2'b10; end
      OP_ADDI: begin ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; end
      OP_LW:   begin
        ctrl.alu_src = 1'b1; ctrl.mem_read = 1'b1;
        ctrl.mem_to_reg = 1'b1; ctrl.reg_write = 1'b1;
      end
      OP_SW:   begin ctrl.alu_src = 1'b1; ctrl.mem_write = 1'b1; end
      OP_BEQ:  begin ctrl.branch = 1'b1; ctrl.alu_op = 2'b01; end
      OP_J:    ctrl.jump = 1'b1;
      default: ctrl = '0;
    endcase
  end

  // Only ops that actually source rt can create a hazard through it
  always_comb begin
    uses_rt = (op == OP_R) || (op == OP_SW) || (op == OP_BEQ);
    hazard  = ex_q.ctrl.mem_read && (ex_q.rt != 5'd0) &&
              ((ex_q.rt == rs) || ((ex_q.rt == rt) && uses_rt));
    Stall   = hazard && !Flush;
  end

  always_comb begin
    ex_d.pc      = nextPC;
    ex_d.rs_data = rs_rd;
    ex_d.rt_data = rt_rd;
    ex_d.imm     = {{(32-IMM_W){Ins[IMM_W-1]}}, Ins[IMM_W-1:0]};
    ex_d.jaddr   = {nextPC[31:28], Ins[25:0], 2'b00};
    ex_d.rs      = rs;
    ex_d.rt      = rt;
    ex_d.rd      = Ins[15:11];
    ex_d.shamt   = Ins[10:6];
    ex_d.funct   = Ins[5:0];
    ex_d.ctrl    = (hazard || Flush) ? ctrl_t'('0) : ctrl;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_q <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else begin
      ex_q <= ex_d;
      rf_q <= rf_d;
    end
  end

  assign E_PC       = ex_q.pc;
  assign E_RsData   = ex_q.rs_data;
  assign E_RtData   = ex_q.rt_data;
  assign E_Imm      = ex_q.imm;
  assign E_JAddr    = ex_q.jaddr;
  assign E_Rs       = ex_q.rs;
  assign E_Rt       = ex_q.rt;
  assign E_Rd       = ex_q.rd;
  assign E_Shamt    = ex_q.shamt;
  assign E_Funct    = ex_q.funct;
  assign E_RegWrite = ex_q.ctrl.reg_write;
  assign E_MemRead  = ex_q.ctrl.mem_read;
  assign E_MemWrite = ex_q.ctrl.mem_write;
  assign E_ALUSrc   = ex_q.ctrl.alu_src;
  assign E_RegDst   = ex_q.ctrl.reg_dst;
  assign E_MemtoReg = ex_q.ctrl.mem_to_reg;
  assign E_Branch   = ex_q.ctrl.branch;
  assign E_Jump     = ex_q.ctrl.jump;
  assign E_ALUOp    = ex_q.ctrl.alu_op;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode table, register file, load-use stall and bubbles.
module tb_id_stage;
  logic        CLK = 1'b0;
  logic        RST, W_RegWrite, Flush, Stall;
  logic [31:0] Ins, nextPC, W_Data;
  logic [4:0]  W_RegAddr;
  logic [31:0] E_PC, E_RsData, E_RtData, E_Imm, E_JAddr;
  logic [4:0]  E_Rs, E_Rt, E_Rd, E_Shamt;
  logic [5:0]  E_Funct;
  logic        E_RegWrite, E_MemRead, E_MemWrite, E_ALUSrc, E_RegDst, E_MemtoReg, E_Branch, E_Jump;
  logic [1:0]  E_ALUOp;

  int n_chk = 0, n_pass = 0;

  localparam logic [31:0] I_ADD  = 32'h012A4020; // add r8,r9,r10
  localparam logic [31:0] I_ADDI = 32'h2231FF00; // addi r17,r17,-256
  localparam logic [31:0] I_LW   = 32'h8D280004; // lw r8,4(r9)
  localparam logic [31:0] I_USE  = 32'h010B5020; // add r10,r8,r11
  localparam logic [31:0] I_ADDI8= 32'h21280001; // addi r8,r9,1
  localparam logic [31:0] I_SW   = 32'hAD280000; // sw r8,0(r9)
  localparam logic [31:0] I_BEQ  = 32'h11280003; // beq r9,r8,3
  localparam logic [31:0] I_J    = 32'h08000040; // j 0x40
  localparam logic [31:0] I_LW0  = 32'h8D200000; // lw r0,0(r9)
  localparam logic [31:0] I_RD5  = 32'h00A00820; // add r1,r5,r0

  // {RegWrite,MemRead,MemWrite,ALUSrc,RegDst,MemtoReg,Branch,Jump,ALUOp}
  localparam logic [31:0] C_R    = 32'b1000100010;
  localparam logic [31:0] C_ADDI = 32'b1001000000;
  localparam logic [31:0] C_LW   = 32'b1101010000;
  localparam logic [31:0] C_SW   = 32'b0011000000;
  localparam logic [31:0] C_BEQ  = 32'b0000001001;
  localparam logic [31:0] C_J    = 32'b0000000100;

  id_stage #(.IMM_W(16)) dut (
    .CLK(CLK), .RST(RST), .Ins(Ins), .nextPC(nextPC),
    .W_RegWrite(W_RegWrite), .W_RegAddr(W_RegAddr), .W_Data(W_Data),
    .Flush(Flush), .Stall(Stall), .E_PC(E_PC), .E_RsData(E_RsData),
    .E_RtData(E_RtData), .E_Imm(E_Imm), .E_Rs(E_Rs), .E_Rt(E_Rt), .E_Rd(E_Rd),
    .E_Shamt(E_Shamt), .E_Funct(E_Funct), .E_JAddr(E_JAddr),
    .E_RegWrite(E_RegWrite), .E_MemRead(E_MemRead), .E_MemWrite(E_MemWrite),
    .E_ALUSrc(E_ALUSrc), .E_RegDst(E_RegDst), .E_MemtoReg(E_MemtoReg),
    .E_Branch(E_Branch), .E_Jump(E_Jump), .E_ALUOp(E_ALUOp)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] ctl();
    return {22'd0, E_RegWrite, E_MemRead, E_MemWrite, E_ALUSrc, E_RegDst,
            E_MemtoReg, E_Branch, E_Jump, E_ALUOp};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; Ins = 32'd0; nextPC = 32'd0; Flush = 1'b0;
    W_RegWrite = 1'b0; W_RegAddr = 5'd0; W_Data = 32'd0;
    tick(); tick();
    #1;
    chk("rst_ctl", ctl(), 32'd0);
    chk("rst_pc", E_PC, 32'd0);
    chk("rst_imm", E_Imm, 32'd0);
    chk("rst_jaddr", E_JAddr, 32'd0);
    chk("rst_fields", {E_Rs, E_Rt, E_Rd, E_Shamt, E_Funct}, 32'd0);
    chk("rst_stall", {31'd0, Stall}, 32'd0);
    RST = 1'b0;

    for (int i = 0; i < 32; i++) begin
      Ins = {6'd0, i[4:0], i[4:0], 16'd0};
      tick();
      chk("rst_rf_rs", E_RsData, 32'd0);
      chk("rst_rf_rt", E_RtData, 32'd0);
    end

    // writeback r9 then decode add r8,r9,r10
    W_RegWrite = 1'b1; W_RegAddr = 5'd9; W_Data = 32'hAB; Ins = 32'd0;
    tick();
    W_RegWrite = 1'b0; Ins = I_ADD; nextPC = 32'h100;
    tick();
    chk("wb_rsdata", E_RsData, 32'hAB);
    chk("add_ctl", ctl(), C_R);
    chk("add_rd", {27'd0, E_Rd}, 32'd8);
    chk("add_rt", {27'd0, E_Rt}, 32'd10);
    chk("add_funct", {26'd0, E_Funct}, 32'h20);
    chk("add_pc", E_PC, 32'h100);

    Ins = I_ADDI;
    tick();
    chk("addi_imm", E_Imm, 32'hFFFFFF00);
    chk("addi_ctl", ctl(), C_ADDI);
    chk("addi_rs", {27'd0, E_Rs}, 32'd17);

    // load-use on rs
    Ins = I_LW;
    tick();
    chk("lw_ctl", ctl(), C_LW);
    chk("lw_imm", E_Imm, 32'd4);
    chk("lw_rsdata", E_RsData, 32'hAB);
    Ins = I_USE; #1;
    chk("lu_stall", {31'd0, Stall}, 32'd1);
    tick();
    chk("lu_bubble", ctl(), 32'd0);
    chk("lu_stall_drop", {31'd0, Stall}, 32'd0);
    tick();
    chk("lu_use_ctl", ctl(), C_R);
    chk("lu_use_rd", {27'd0, E_Rd}, 32'd10);

    // flush wins over stall
    Ins = I_LW;
    tick();
    Ins = I_USE; Flush = 1'b1; #1;
    chk("fl_stall", {31'd0, Stall}, 32'd0);
    tick();
    Flush = 1'b0;
    chk("fl_bubble", ctl(), 32'd0);

    // rt match on an op that does not read rt: no stall
    Ins = I_LW;
    tick();
    Ins = I_ADDI8; #1;
    chk("addi_nostall", {31'd0, Stall}, 32'd0);
    tick();
    chk("addi8_ctl", ctl(), C_ADDI);

    // rt match on sw: stall
    Ins = I_LW;
    tick();
    Ins = I_SW; #1;
    chk("sw_stall", {31'd0, Stall}, 32'd1);
    tick();
    chk("sw_bubble", ctl(), 32'd0);
    tick();
    chk("sw_ctl", ctl(), C_SW);

    Ins = I_BEQ;
    tick();
    chk("beq_ctl", ctl(), C_BEQ);
    chk("beq_imm", E_Imm, 32'd3);

    Ins = I_J; nextPC = 32'h90000010;
    tick();
    chk("j_ctl", ctl(), C_J);
    chk("j_jaddr", E_JAddr, 32'h90000100);
    chk("j_pc", E_PC, 32'h90000010);

    Ins = 32'hFC000000;
    tick();
    chk("badop_ctl", ctl(), 32'd0);

    Ins = I_ADDI; Flush = 1'b1;
    tick();
    Flush = 1'b0;
    chk("flush_ctl", ctl(), 32'd0);

    // lw into r0 never stalls
    Ins = I_LW0;
    tick();
    Ins = 32'h00000020; #1;
    chk("r0_nostall", {31'd0, Stall}, 32'd0);

    // writes to r0 ignored, even in the same cycle
    W_RegWrite = 1'b1; W_RegAddr = 5'd0; W_Data = 32'hFFFFFFFF; Ins = 32'd0;
    tick();
    chk("r0_same", E_RsData, 32'd0);
    W_RegWrite = 1'b0;
    tick();
    chk("r0_rs", E_RsData, 32'd0);
    chk("r0_rt", E_RtData, 32'd0);

    // same-cycle write/read of r5
    W_RegWrite = 1'b1; W_RegAddr = 5'd5; W_Data = 32'h1234; Ins = I_RD5;
    tick();
    W_RegWrite = 1'b0;
`ifdef ID_BYPASS_EN
    chk("byp_rs", E_RsData, 32'h1234);
`else
    chk("byp_rs", E_RsData, 32'd0);
`endif
    tick();
    chk("r5_rs", E_RsData, 32'h1234);

    // reset beats writeback and flush
    RST = 1'b1; Flush = 1'b1; W_RegWrite = 1'b1; W_RegAddr = 5'd5; W_Data = 32'h5555;
    tick();
    RST = 1'b0; Flush = 1'b0; W_RegWrite = 1'b0;
    chk("rst2_ctl", ctl(), 32'd0);
    chk("rst2_pc", E_PC, 32'd0);
    tick();
    chk("rst2_r5", E_RsData, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
